// File: rtl/demux_1to8_reg.sv
// demux_1to8_reg: registered 1-to-8 demultiplexer with valid/ready handshakes.
// One word plus its destination is held in a single output register and shown
// on exactly one channel until that channel accepts. While the held word drains,
// a new word can load in the same cycle, so the block sustains one word per cycle.
// Optional build macro DEMUX_AUTO_SEL_EN: destinations come from an internal
// round-robin pointer instead of in_sel.
module demux_1to8_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic [WIDTH-1:0] y7,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [15:0]      cnt_accepted
);

    logic [WIDTH-1:0] hold_data_q;
    logic [WIDTH-1:0] hold_data_d;
    logic [2:0]       hold_sel_q;
    logic [2:0]       hold_sel_d;
    logic             full_q;
    logic             full_d;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;
    logic [2:0]       load_sel_s;
    logic             accept_s;
    logic             xfer_s;
    logic             dst_ready_s;
    logic [WIDTH-1:0] y_s [8];

`ifdef DEMUX_AUTO_SEL_EN
    logic [2:0] rr_ptr_q;
    logic [2:0] rr_ptr_d;

    // Advance the round-robin pointer once per accepted word, wrapping 7 -> 0.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept_s) begin
            rr_ptr_d = rr_ptr_q + 3'd1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 3'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // The pre-increment pointer value is the destination of the word being loaded.
    assign load_sel_s = rr_ptr_q;
`else
    assign load_sel_s = in_sel;
`endif

    // Handshake decode: only the selected channel's ready can drain the register.
    always_comb begin
        dst_ready_s = out_ready[hold_sel_q];
        xfer_s      = full_q & dst_ready_s;
        in_ready    = ~full_q | dst_ready_s;
        accept_s    = in_valid & in_ready;
    end

    // Next-state for the holding register and delivery counter.
    always_comb begin
        hold_data_d = hold_data_q;
        hold_sel_d  = hold_sel_q;
        full_d      = full_q;
        cnt_d       = cnt_q;
        if (accept_s) begin
            hold_data_d = in_data;
            hold_sel_d  = load_sel_s;
            full_d      = 1'b1;
        end else if (xfer_s) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
        if (xfer_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset discards any held word and clears the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_q <= {WIDTH{1'b0}};
            hold_sel_q  <= 3'd0;
            full_q      <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_sel_q  <= hold_sel_d;
            full_q      <= full_d;
            cnt_q       <= cnt_d;
        end
    end

    // Output decode from registers only: the held word appears on one channel.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            if (full_q && (hold_sel_q == k[2:0])) begin
                y_s[k] = hold_data_q;
            end else begin
                y_s[k] = {WIDTH{1'b0}};
            end
        end
        if (full_q) begin
            out_valid = 8'd1 << hold_sel_q;
        end else begin
            out_valid = 8'd0;
        end
    end

    assign y0           = y_s[0];
    assign y1           = y_s[1];
    assign y2           = y_s[2];
    assign y3           = y_s[3];
    assign y4           = y_s[4];
    assign y5           = y_s[5];
    assign y6           = y_s[6];
    assign y7           = y_s[7];
    assign cnt_accepted = cnt_q;

endmodule

// File: tb/tb_demux_1to8_reg.sv
// Self-checking bench for demux_1to8_reg. A queue-based model holds at most one
// word; every cycle the DUT outputs are compared against it, and a few directed
// sequences pin the model with hand-computed values. Honours DEMUX_AUTO_SEL_EN.
module tb_demux_1to8_reg;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data;
    logic [2:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_valid;
    logic [7:0]    out_ready;
    logic [15:0]   cnt;
    logic [W-1:0]  y_w [8];

    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   s;
    } word_t;

    word_t slot[$];
    int    m_cnt;
    int    m_rr;
    int    errors;
    int    checks;
    bit    model_ok;

    always #5 clk = ~clk;

    demux_1to8_reg #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_sel       (in_sel),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .y0           (y_w[0]),
        .y1           (y_w[1]),
        .y2           (y_w[2]),
        .y3           (y_w[3]),
        .y4           (y_w[4]),
        .y5           (y_w[5]),
        .y6           (y_w[6]),
        .y7           (y_w[7]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cnt_accepted (cnt)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return (slot.size() == 0) || out_ready[slot[0].s];
    endfunction

    // Apply inputs at the falling edge, then compare all outputs to the model.
    task automatic drive(input logic r, input logic v, input logic [2:0] s,
                         input logic [W-1:0] d, input logic [7:0] ordy);
        @(negedge clk);
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
        #1;
        if (model_ok) begin
            logic [7:0]   ev;
            logic [W-1:0] ey;
            ev = 8'd0;
            if (slot.size() > 0) ev[slot[0].s] = 1'b1;
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
            chk("out_valid", {24'd0, out_valid}, {24'd0, ev});
            chk("cnt_accepted", {16'd0, cnt}, m_cnt);
            for (int k = 0; k < 8; k++) begin
                ey = 32'd0;
                if (slot.size() > 0 && slot[0].s == k) ey = slot[0].d;
                chk($sformatf("y%0d", k), y_w[k], ey);
            end
        end
    endtask

    // Advance one clock edge and update the model from the spec's rules.
    task automatic tick();
        bit    x;
        bit    a;
        word_t w;
        x = (slot.size() > 0) && out_ready[slot[0].s];
        a = in_valid && exp_ready();
        @(posedge clk);
        if (rst) begin
            slot.delete();
            m_cnt    = 0;
            m_rr     = 0;
            model_ok = 1'b1;
        end else begin
            if (x) begin
                void'(slot.pop_front());
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (a) begin
`ifdef DEMUX_AUTO_SEL_EN
                w.s  = m_rr[2:0];
                m_rr = (m_rr + 1) % 8;
`else
                w.s  = in_sel;
`endif
                w.d = in_data;
                slot.push_back(w);
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [2:0] s,
                        input logic [W-1:0] d, input logic [7:0] ordy);
        drive(r, v, s, d, ordy);
        tick();
    endtask

    initial begin
        errors = 0; checks = 0; model_ok = 1'b0; m_cnt = 0; m_rr = 0;
        rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = 32'd0; out_ready = 8'h00;

        // Reset with in_valid high: nothing may be accepted.
        step(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 8'h00);
        step(1'b1, 1'b0, 3'd0, 32'd0, 8'h00);

        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'h00);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {24'd0, out_valid}, 32'd0);
        chk("rst_cnt", {16'd0, cnt}, 32'd0);
        tick();

`ifndef DEMUX_AUTO_SEL_EN
        // Single word to channel 5.
        step(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 8'hFF);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'hFF);
        chk("dir_ov5", {24'd0, out_valid}, 32'h20);
        chk("dir_y5", y_w[5], 32'hDEAD_BEEF);
        chk("dir_y0", y_w[0], 32'd0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'hFF);
        chk("dir_cnt1", {16'd0, cnt}, 32'd1);
        tick();

        // Stall on channel 2 with a second word waiting.
        step(1'b0, 1'b1, 3'd2, 32'h1234, 8'hFB);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 3'd4, 32'h5678, 8'hFB);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_y2", y_w[2], 32'h1234);
            tick();
        end
        drive(1'b0, 1'b1, 3'd4, 32'h5678, 8'hFF);
        chk("drainload_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'hFF);
        chk("drainload_ov", {24'd0, out_valid}, 32'h10);
        chk("drainload_y4", y_w[4], 32'h5678);
        chk("drainload_cnt", {16'd0, cnt}, 32'd2);
        tick();

        // Streaming eight words to channels 0..7.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, i[2:0], i + 1, 8'hFF);
            if (i > 0) chk("stream_walk", {24'd0, out_valid}, 32'd1 << (i - 1));
            tick();
        end
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'hFF);
        chk("stream_ov80", {24'd0, out_valid}, 32'h80);
        chk("stream_y7", y_w[7], 32'd8);
        chk("stream_cnt10", {16'd0, cnt}, 32'd10);
        tick();
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'h00);
        chk("stream_cnt11", {16'd0, cnt}, 32'd11);
        tick();

        // Reset while a word is stalled on channel 3.
        step(1'b0, 1'b1, 3'd3, 32'hAA, 8'hF7);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'hF7);
        chk("midstall_ov", {24'd0, out_valid}, 32'h08);
        tick();
        step(1'b1, 1'b1, 3'd1, 32'hBB, 8'hF7);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'hFF);
        chk("postrst_ov", {24'd0, out_valid}, 32'd0);
        chk("postrst_y3", y_w[3], 32'd0);
        chk("postrst_cnt", {16'd0, cnt}, 32'd0);
        chk("postrst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'hFF);
        chk("postrst_cnt_still0", {16'd0, cnt}, 32'd0);
        tick();
`else
        // Round-robin destinations ignore in_sel: 0,1,...,7,0.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, (i < 9) ? 1'b1 : 1'b0, 3'd6, 32'd100 + i, 8'hFF);
            if (i > 0) chk("rr_dest", {24'd0, out_valid}, 32'd1 << ((i - 1) % 8));
            tick();
        end
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       v;
            logic [7:0] o;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            step(r, v, 3'($urandom), $urandom, o);
        end

        // Counter wrap: 65536 deliveries from reset return the count to zero.
        step(1'b1, 1'b0, 3'd0, 32'd0, 8'hFF);
        for (int n = 0; n <= 65536; n++) begin
            drive(1'b0, 1'b1, 3'($urandom), n, 8'hFF);
            if (n == 65536) chk("cnt_ffff", {16'd0, cnt}, 32'h0000_FFFF);
            tick();
        end
        drive(1'b0, 1'b0, 3'd0, 32'd0, 8'hFF);
        chk("cnt_wrap", {16'd0, cnt}, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
